router_ctrl: RTL

Packet-level controller of the 1x3 router. It accepts a byte stream from the single input port, decodes the header's destination address and sequences writes into one of the three output `router_fifo` instances. It applies back-pressure when the selected FIFO is not ready, checks packet parity, and soft-resets any output FIFO whose reader stalls. It sits between the router input port and the three FIFOs' `write_enb`, `lfd_state` and `soft_reset` pins.

---
 rtl/router_pkg.sv | 53 +++++
 rtl/router_timeout.sv | 38 +++
 rtl/router_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router controller.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE,
        LOAD_DATA,
        LOAD_PARITY,
        CHECK,
        DROP
    } state_t;

    localparam logic [1:0] ADDR0        = 2'b00;
    localparam logic [1:0] ADDR1        = 2'b01;
    localparam logic [1:0] ADDR2        = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;
    localparam int unsigned ADDR_W       = HDR_ADDR_MSB - HDR_ADDR_LSB + 1;
    localparam int unsigned REM_W        = LEN_W + 1;
    localparam int unsigned NUM_PORTS    = 3;
    localparam int unsigned DEFAULT_TIMEOUT = 30;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } header_t;

    // Per-port flag selected by address; the invalid address returns oob.
    function automatic logic sel_bit(input logic [NUM_PORTS-1:0] v,
                                     input logic [ADDR_W-1:0] a,
                                     input logic oob);
        case (a)
            ADDR0:   sel_bit = v[0];
            ADDR1:   sel_bit = v[1];
            ADDR2:   sel_bit = v[2];
            default: sel_bit = oob;
        endcase
    endfunction

    function automatic logic [NUM_PORTS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        case (a)
            ADDR0:   addr_onehot = 3'b001;
            ADDR1:   addr_onehot = 3'b010;
            ADDR2:   addr_onehot = 3'b100;
            default: addr_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/router_timeout.sv
// Stalled-reader watchdog for one output FIFO: pulses soft_reset after
// TIMEOUT consecutive cycles of valid data that nobody reads.
module router_timeout
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic vld_out,
    input  logic read_enb,
    output logic soft_reset
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (vld_out && !read_enb) begin
                if (cnt == CW'(TIMEOUT - 1)) begin
                    cnt        <= '0;
                    soft_reset <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// Packet-level controller of the 1x3 router: header decode, FIFO write
// sequencing with back-pressure, parity check and stalled-reader recovery.
module router_ctrl
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 lfd_state,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic                 err
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;       // bytes still due after the header, parity included
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        parity_q, parity_d;
    logic              accept;
    header_t           hdr;

    assign hdr     = header_t'(data_in);
    assign vld_out = ~fifo_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= DECODE;
            addr_q   <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            parity_q <= '0;
        end else begin
            state    <= next_state;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        next_state = state;
        addr_d     = addr_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        parity_d   = parity_q;
        busy       = 1'b0;
        accept     = 1'b0;
        write_enb  = '0;
        lfd_state  = 1'b0;
        err        = 1'b0;

        case (state)
            DECODE: begin
                // A packet may only start into an empty FIFO.
                busy   = pkt_valid && !sel_bit(fifo_empty, hdr.addr, 1'b1);
                accept = pkt_valid && !busy;
                if (accept) begin
                    rem_d = REM_W'(hdr.len) + REM_W'(1);
                    if (hdr.addr == ADDR_INVALID) begin
                        next_state = DROP;
                    end else begin
                        write_enb  = addr_onehot(hdr.addr);
                        lfd_state  = 1'b1;
                        addr_d     = hdr.addr;
                        acc_d      = data_in;
                        next_state = (hdr.len == '0) ? LOAD_PARITY : LOAD_DATA;
                    end
                end
            end

            LOAD_DATA, LOAD_PARITY: begin
                if (sel_bit(soft_reset, addr_q, 1'b0)) begin
                    // Target FIFO was flushed: discard the rest of the packet.
                    accept     = pkt_valid;
                    next_state = DROP;
                    if (accept) begin
                        rem_d = rem_q - REM_W'(1);
                        if (rem_q == REM_W'(1)) next_state = DECODE;
                    end
                end else begin
                    busy   = sel_bit(fifo_full, addr_q, 1'b0);
                    accept = pkt_valid && !busy;
                    if (accept) begin
                        write_enb = addr_onehot(addr_q);
                        rem_d     = rem_q - REM_W'(1);
                        if (state == LOAD_DATA) begin
                            acc_d = acc_q ^ data_in;
                            if (rem_q == REM_W'(2)) next_state = LOAD_PARITY;
                        end else begin
                            parity_d   = data_in;
                            next_state = CHECK;
                        end
                    end
                end
            end

            CHECK: begin
                busy       = 1'b1;
                err        = (acc_q != parity_q);
                next_state = DECODE;
            end

            DROP: begin
                accept = pkt_valid;
                if (accept) begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) next_state = DECODE;
                end
            end

            default: next_state = DECODE;
        endcase
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timeout
        router_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
            .clock      (clock),
            .reset      (reset),
            .vld_out    (vld_out[i]),
            .read_enb   (read_enb[i]),
            .soft_reset (soft_reset[i])
        );
    end

endmodule
